// File: rtl/alu_rs.sv
// -----------------------------------------------------------------------------
// alu_rs -- reservation station in front of a single combinational ALU.
//
// Instructions are issued into the lowest free entry. Pending operands are
// resolved either at issue time (same-cycle CDB bypass) or later by wakeup from
// either common data bus. Each cycle the lowest-index entry with both operands
// resolved is registered onto the alu_* outputs and its entry is freed.
//
// Parameters
//   RS_SZ       number of entries (power of two, 2..16)
//   ROB_SZ_LOG  ROB tags are ROB_SZ_LOG+1 bits wide
//
// Ports
//   clk_in, rst_in           clock, synchronous active-high reset
//   rdy_in                   chip ready; low freezes the station
//   clr_in                   mispredict flush (drops every entry)
//   iss_*                    issue request: opcode, operands, tags, imm, pc, rd
//   cdb0_* / cdb1_*          result broadcasts (ALU / load-store)
//   full_out                 every entry busy (combinational)
//   alu_run, alu_*           registered dispatch to the ALU
// -----------------------------------------------------------------------------
module alu_rs #(
    parameter int RS_SZ      = 8,
    parameter int ROB_SZ_LOG = 3
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  clr_in,

    input  logic                  iss_vld,
    input  logic [3:0]            iss_op,
    input  logic [31:0]           iss_Vj,
    input  logic [31:0]           iss_Vk,
    input  logic                  iss_Qj_vld,
    input  logic                  iss_Qk_vld,
    input  logic [ROB_SZ_LOG:0]   iss_Qj,
    input  logic [ROB_SZ_LOG:0]   iss_Qk,
    input  logic [31:0]           iss_imm,
    input  logic [31:0]           iss_pc,
    input  logic [ROB_SZ_LOG:0]   iss_rd,

    input  logic                  cdb0_vld,
    input  logic [ROB_SZ_LOG:0]   cdb0_tag,
    input  logic [31:0]           cdb0_val,
    input  logic                  cdb1_vld,
    input  logic [ROB_SZ_LOG:0]   cdb1_tag,
    input  logic [31:0]           cdb1_val,

    output logic                  full_out,
    output logic                  alu_run,
    output logic [3:0]            alu_op,
    output logic [31:0]           alu_Vj,
    output logic [31:0]           alu_Vk,
    output logic [31:0]           alu_imm,
    output logic [31:0]           alu_pc,
    output logic [ROB_SZ_LOG:0]   alu_rd
);

    localparam int IDX_W = $clog2(RS_SZ);

    typedef logic [ROB_SZ_LOG:0] tag_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] vj;
        logic        qj_vld;
        tag_t        qj;
        logic [31:0] vk;
        logic        qk_vld;
        tag_t        qk;
        logic [31:0] imm;
        logic [31:0] pc;
        tag_t        rd;
    } entry_t;

    logic [RS_SZ-1:0] busy_q, busy_d;
    entry_t           ent_q [RS_SZ];
    entry_t           ent_d [RS_SZ];

    logic             alu_run_q, alu_run_d;
    logic [3:0]       alu_op_q,  alu_op_d;
    logic [31:0]      alu_vj_q,  alu_vj_d;
    logic [31:0]      alu_vk_q,  alu_vk_d;
    logic [31:0]      alu_imm_q, alu_imm_d;
    logic [31:0]      alu_pc_q,  alu_pc_d;
    tag_t             alu_rd_q,  alu_rd_d;

    logic [IDX_W-1:0] iss_idx;
    logic [IDX_W-1:0] disp_idx;
    logic             disp_ok;

    // A tag is resolved if either bus carries it; cdb0 wins if both do.
    function automatic logic cdb_hit(input tag_t tag);
        return (cdb0_vld && cdb0_tag == tag) || (cdb1_vld && cdb1_tag == tag);
    endfunction

    function automatic logic [31:0] cdb_val(input tag_t tag);
        return (cdb0_vld && cdb0_tag == tag) ? cdb0_val : cdb1_val;
    endfunction

    assign full_out = &busy_q;

    // Priority pick: scanning downward leaves the lowest matching index.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        iss_idx  = '0;
        disp_idx = '0;
        disp_ok  = 1'b0;
        for (int i = RS_SZ - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                iss_idx = IDX_W'(i);
            end
            if (busy_q[i] && !ent_q[i].qj_vld && !ent_q[i].qk_vld) begin
                disp_idx = IDX_W'(i);
                disp_ok  = 1'b1;
            end
        end
    end

    // Wakeup, dispatch and issue touch disjoint entries: wakeup only changes
    // pending operands, the dispatched entry has none, and the issue slot was
    // free before the edge. So applying them in sequence is order-independent.
    always_comb begin
        // NOTE: combinational blocks use blocking (=) so later statements see earlier updates.
        busy_d    = busy_q;
        ent_d     = ent_q;
        alu_run_d = 1'b0;
        alu_op_d  = alu_op_q;
        alu_vj_d  = alu_vj_q;
        alu_vk_d  = alu_vk_q;
        alu_imm_d = alu_imm_q;
        alu_pc_d  = alu_pc_q;
        alu_rd_d  = alu_rd_q;

        if (clr_in) begin
            busy_d = '0;
        end else if (rdy_in) begin
            for (int i = 0; i < RS_SZ; i++) begin
                if (busy_q[i] && ent_q[i].qj_vld && cdb_hit(ent_q[i].qj)) begin
                    ent_d[i].vj     = cdb_val(ent_q[i].qj);
                    ent_d[i].qj_vld = 1'b0;
                end
                if (busy_q[i] && ent_q[i].qk_vld && cdb_hit(ent_q[i].qk)) begin
                    ent_d[i].vk     = cdb_val(ent_q[i].qk);
                    ent_d[i].qk_vld = 1'b0;
                end
            end

            if (disp_ok) begin
                alu_run_d        = 1'b1;
                alu_op_d         = ent_q[disp_idx].op;
                alu_vj_d         = ent_q[disp_idx].vj;
                alu_vk_d         = ent_q[disp_idx].vk;
                alu_imm_d        = ent_q[disp_idx].imm;
                alu_pc_d         = ent_q[disp_idx].pc;
                alu_rd_d         = ent_q[disp_idx].rd;
                busy_d[disp_idx] = 1'b0;
            end

            // full_out is pre-edge state, so a slot freed by dispatch this
            // cycle is not offered to the issue.
            if (iss_vld && !full_out) begin
                busy_d[iss_idx]        = 1'b1;
                ent_d[iss_idx].op      = iss_op;
                ent_d[iss_idx].imm     = iss_imm;
                ent_d[iss_idx].pc      = iss_pc;
                ent_d[iss_idx].rd      = iss_rd;
                ent_d[iss_idx].qj      = iss_Qj;
                ent_d[iss_idx].qk      = iss_Qk;
                ent_d[iss_idx].qj_vld  = iss_Qj_vld && !cdb_hit(iss_Qj);
                ent_d[iss_idx].qk_vld  = iss_Qk_vld && !cdb_hit(iss_Qk);
                ent_d[iss_idx].vj      = (iss_Qj_vld && cdb_hit(iss_Qj)) ? cdb_val(iss_Qj) : iss_Vj;
                ent_d[iss_idx].vk      = (iss_Qk_vld && cdb_hit(iss_Qk)) ? cdb_val(iss_Qk) : iss_Vk;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_q    <= '0;
            alu_run_q <= 1'b0;
            alu_op_q  <= '0;
            alu_vj_q  <= '0;
            alu_vk_q  <= '0;
            alu_imm_q <= '0;
            alu_pc_q  <= '0;
            alu_rd_q  <= '0;
        end else begin
            busy_q    <= busy_d;
            alu_run_q <= alu_run_d;
            alu_op_q  <= alu_op_d;
            alu_vj_q  <= alu_vj_d;
            alu_vk_q  <= alu_vk_d;
            alu_imm_q <= alu_imm_d;
            alu_pc_q  <= alu_pc_d;
            alu_rd_q  <= alu_rd_d;
        end
    end

    // NOTE: entry payload has no reset; it is only ever read while its busy bit is set.
    always_ff @(posedge clk_in) begin
        ent_q <= ent_d;
    end

    assign alu_run = alu_run_q;
    assign alu_op  = alu_op_q;
    assign alu_Vj  = alu_vj_q;
    assign alu_Vk  = alu_vk_q;
    assign alu_imm = alu_imm_q;
    assign alu_pc  = alu_pc_q;
    assign alu_rd  = alu_rd_q;

endmodule

// File: tb/tb_alu_rs.sv
// -----------------------------------------------------------------------------
// tb_alu_rs -- self-checking bench for alu_rs (RS_SZ=8, 4-bit tags).
// Directed scenarios first, then randomized traffic, all compared against a
// behavioural model of the station's rules.
// -----------------------------------------------------------------------------
module tb_alu_rs;

    localparam int RS_SZ      = 8;
    localparam int ROB_SZ_LOG = 3;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clr_in;
    logic        iss_vld, iss_Qj_vld, iss_Qk_vld;
    logic [3:0]  iss_op, iss_Qj, iss_Qk, iss_rd;
    logic [31:0] iss_Vj, iss_Vk, iss_imm, iss_pc;
    logic        cdb0_vld, cdb1_vld;
    logic [3:0]  cdb0_tag, cdb1_tag;
    logic [31:0] cdb0_val, cdb1_val;
    logic        full_out, alu_run;
    logic [3:0]  alu_op, alu_rd;
    logic [31:0] alu_Vj, alu_Vk, alu_imm, alu_pc;

    int checks = 0;
    int errors = 0;
    bit known  = 1'b0;

    alu_rs #(.RS_SZ(RS_SZ), .ROB_SZ_LOG(ROB_SZ_LOG)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
        .iss_vld(iss_vld), .iss_op(iss_op), .iss_Vj(iss_Vj), .iss_Vk(iss_Vk),
        .iss_Qj_vld(iss_Qj_vld), .iss_Qk_vld(iss_Qk_vld), .iss_Qj(iss_Qj), .iss_Qk(iss_Qk),
        .iss_imm(iss_imm), .iss_pc(iss_pc), .iss_rd(iss_rd),
        .cdb0_vld(cdb0_vld), .cdb0_tag(cdb0_tag), .cdb0_val(cdb0_val),
        .cdb1_vld(cdb1_vld), .cdb1_tag(cdb1_tag), .cdb1_val(cdb1_val),
        .full_out(full_out), .alu_run(alu_run), .alu_op(alu_op),
        .alu_Vj(alu_Vj), .alu_Vk(alu_Vk), .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_rd(alu_rd)
    );

    always #5 clk_in = ~clk_in;

    // ---------------- behavioural model ----------------
    typedef struct {
        bit          busy;
        logic [3:0]  op;
        logic [31:0] vj, vk, imm, pc;
        bit          qjv, qkv;
        logic [3:0]  qj, qk, rd;
    } ment_t;

    ment_t       m [RS_SZ];
    bit          m_run;
    logic [3:0]  m_op, m_rd;
    logic [31:0] m_vj, m_vk, m_imm, m_pc;

    function automatic bit model_full();
        for (int i = 0; i < RS_SZ; i++) if (!m[i].busy) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit bus_has(input logic [3:0] tag);
        return (cdb0_vld && cdb0_tag == tag) || (cdb1_vld && cdb1_tag == tag);
    endfunction

    function automatic logic [31:0] bus_val(input logic [3:0] tag);
        if (cdb0_vld && cdb0_tag == tag) return cdb0_val;
        return cdb1_val;
    endfunction

    // Advance the model across one rising edge using the current inputs.
    task automatic model_edge();
        int d = -1;
        int f = -1;
        if (rst_in) begin
            foreach (m[i]) m[i].busy = 1'b0;
            m_run = 1'b0; m_op = '0; m_vj = '0; m_vk = '0; m_imm = '0; m_pc = '0; m_rd = '0;
            return;
        end
        if (clr_in) begin
            foreach (m[i]) m[i].busy = 1'b0;
            m_run = 1'b0;
            return;
        end
        if (!rdy_in) begin
            m_run = 1'b0;
            return;
        end
        for (int i = 0; i < RS_SZ; i++) begin
            if (d < 0 && m[i].busy && !m[i].qjv && !m[i].qkv) d = i;
            if (f < 0 && !m[i].busy) f = i;
        end
        for (int i = 0; i < RS_SZ; i++) begin
            if (m[i].busy && m[i].qjv && bus_has(m[i].qj)) begin m[i].vj = bus_val(m[i].qj); m[i].qjv = 1'b0; end
            if (m[i].busy && m[i].qkv && bus_has(m[i].qk)) begin m[i].vk = bus_val(m[i].qk); m[i].qkv = 1'b0; end
        end
        m_run = (d >= 0);
        if (d >= 0) begin
            m_op = m[d].op; m_vj = m[d].vj; m_vk = m[d].vk;
            m_imm = m[d].imm; m_pc = m[d].pc; m_rd = m[d].rd;
            m[d].busy = 1'b0;
        end
        if (iss_vld && f >= 0) begin
            m[f].busy = 1'b1;
            m[f].op = iss_op; m[f].imm = iss_imm; m[f].pc = iss_pc; m[f].rd = iss_rd;
            m[f].qj = iss_Qj; m[f].qk = iss_Qk;
            m[f].qjv = iss_Qj_vld && !bus_has(iss_Qj);
            m[f].qkv = iss_Qk_vld && !bus_has(iss_Qk);
            m[f].vj  = (iss_Qj_vld && bus_has(iss_Qj)) ? bus_val(iss_Qj) : iss_Vj;
            m[f].vk  = (iss_Qk_vld && bus_has(iss_Qk)) ? bus_val(iss_Qk) : iss_Vk;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check full_out before the edge, then all outputs after it.
    task automatic step();
        if (known) chk("full_out", 32'(full_out), 32'(model_full()));
        model_edge();
        @(posedge clk_in);
        #1;
        known = 1'b1;
        chk("alu_run", 32'(alu_run), 32'(m_run));
        chk("alu_op",  32'(alu_op),  32'(m_op));
        chk("alu_Vj",  alu_Vj,       m_vj);
        chk("alu_Vk",  alu_Vk,       m_vk);
        chk("alu_imm", alu_imm,      m_imm);
        chk("alu_pc",  alu_pc,       m_pc);
        chk("alu_rd",  32'(alu_rd),  32'(m_rd));
    endtask

    task automatic idle();
        iss_vld = 1'b0; cdb0_vld = 1'b0; cdb1_vld = 1'b0; clr_in = 1'b0;
    endtask

    task automatic set_iss(input logic [3:0] op, input logic [31:0] vj, input logic [31:0] vk,
                           input logic qjv, input logic [3:0] qj,
                           input logic qkv, input logic [3:0] qk, input logic [3:0] rd);
        iss_vld = 1'b1; iss_op = op; iss_Vj = vj; iss_Vk = vk;
        iss_Qj_vld = qjv; iss_Qj = qj; iss_Qk_vld = qkv; iss_Qk = qk; iss_rd = rd;
        iss_imm = 32'h100 + 32'(rd); iss_pc = 32'h1000 + 32'(rd) * 4;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; clr_in = 1'b0;
        iss_vld = 1'b0; iss_op = '0; iss_Vj = '0; iss_Vk = '0; iss_Qj_vld = 1'b0; iss_Qk_vld = 1'b0;
        iss_Qj = '0; iss_Qk = '0; iss_imm = '0; iss_pc = '0; iss_rd = '0;
        cdb0_vld = 1'b0; cdb0_tag = '0; cdb0_val = '0;
        cdb1_vld = 1'b0; cdb1_tag = '0; cdb1_val = '0;
        #1;
        step(); step();
        chk("rst_full", 32'(full_out), 32'd0);
        rst_in = 1'b0;

        // Ready issue dispatches the next cycle, then alu_run drops.
        set_iss(4'h0, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd5);
        step();
        idle(); step();
        chk("add_run", 32'(alu_run), 32'd1);
        chk("add_vj",  alu_Vj, 32'd5);
        chk("add_vk",  alu_Vk, 32'd7);
        chk("add_rd",  32'(alu_rd), 32'd5);
        step();
        chk("add_run_drop", 32'(alu_run), 32'd0);

        // Pending Qj=3 woken by cdb1 one cycle after issue.
        set_iss(4'h1, 32'd0, 32'd3, 1'b1, 4'd3, 1'b0, 4'd0, 4'd6);
        step();
        idle(); cdb1_vld = 1'b1; cdb1_tag = 4'd3; cdb1_val = 32'h10;
        step();
        chk("wake_not_yet", 32'(alu_run), 32'd0);
        idle(); step();
        chk("wake_run", 32'(alu_run), 32'd1);
        chk("wake_vj",  alu_Vj, 32'h10);

        // Issue-time bypass of Qk=2 from cdb0.
        set_iss(4'h2, 32'd1, 32'd0, 1'b0, 4'd0, 1'b1, 4'd2, 4'd7);
        cdb0_vld = 1'b1; cdb0_tag = 4'd2; cdb0_val = 32'd9;
        step();
        idle(); step();
        chk("byp_run", 32'(alu_run), 32'd1);
        chk("byp_vk",  alu_Vk, 32'd9);
        step(); step();

        // Fill all entries pending on tag 1, drop a 9th, then release in order.
        for (int k = 0; k < RS_SZ; k++) begin
            set_iss(4'h3, 32'd0, 32'(k), 1'b1, 4'd1, 1'b0, 4'd0, 4'(k));
            step();
        end
        chk("fill_full", 32'(full_out), 32'd1);
        set_iss(4'h3, 32'd0, 32'hDEAD, 1'b0, 4'd0, 1'b0, 4'd0, 4'd15);
        step();
        idle(); cdb0_vld = 1'b1; cdb0_tag = 4'd1; cdb0_val = 32'h55;
        step();
        idle();
        for (int k = 0; k < RS_SZ; k++) begin
            step();
            chk("fill_run", 32'(alu_run), 32'd1);
            chk("fill_rd",  32'(alu_rd), 32'(k));
            chk("fill_vj",  alu_Vj, 32'h55);
            if (k == 0) chk("fill_full_drop", 32'(full_out), 32'd0);
        end
        step();
        chk("fill_drained", 32'(alu_run), 32'd0);

        // Flush with concurrent issue: nothing survives.
        for (int k = 0; k < 4; k++) begin
            set_iss(4'h4, 32'd0, 32'd0, 1'b1, 4'd9, 1'b0, 4'd0, 4'(8 + k));
            step();
        end
        set_iss(4'h4, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd12);
        clr_in = 1'b1;
        step();
        idle();
        chk("clr_full", 32'(full_out), 32'd0);
        chk("clr_run",  32'(alu_run), 32'd0);
        cdb0_vld = 1'b1; cdb0_tag = 4'd9; cdb0_val = 32'h77;
        step();
        idle();
        for (int k = 0; k < 3; k++) begin
            step();
            chk("clr_no_disp", 32'(alu_run), 32'd0);
        end

        // Freeze: ready entry held, issue during freeze ignored.
        set_iss(4'h5, 32'h11, 32'h22, 1'b0, 4'd0, 1'b0, 4'd0, 4'd2);
        step();
        idle(); rdy_in = 1'b0;
        set_iss(4'h6, 32'h33, 32'h44, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("frz_run", 32'(alu_run), 32'd0);
            idle();
        end
        rdy_in = 1'b1;
        step();
        chk("frz_resume_run", 32'(alu_run), 32'd1);
        chk("frz_resume_rd",  32'(alu_rd), 32'd2);
        step();
        chk("frz_issue_dropped", 32'(alu_run), 32'd0);

        // Reset while an entry is about to dispatch.
        set_iss(4'h7, 32'h99, 32'h98, 1'b0, 4'd0, 1'b0, 4'd0, 4'd4);
        step();
        idle(); rst_in = 1'b1; clr_in = 1'b1; rdy_in = 1'b0;
        step();
        chk("rst_mid_run", 32'(alu_run), 32'd0);
        chk("rst_mid_vj",  alu_Vj, 32'd0);
        rst_in = 1'b0; clr_in = 1'b0; rdy_in = 1'b1;
        step();
        chk("rst_mid_gone", 32'(alu_run), 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            rst_in  = ($urandom_range(0, 63) == 0);
            clr_in  = ($urandom_range(0, 31) == 0);
            rdy_in  = ($urandom_range(0, 7) != 0);
            iss_vld = 1'($urandom_range(0, 1));
            iss_op  = 4'($urandom);
            iss_Vj  = $urandom; iss_Vk = $urandom;
            iss_Qj_vld = 1'($urandom_range(0, 1)); iss_Qj = 4'($urandom_range(0, 7));
            iss_Qk_vld = 1'($urandom_range(0, 1)); iss_Qk = 4'($urandom_range(0, 7));
            iss_imm = $urandom; iss_pc = $urandom; iss_rd = 4'($urandom);
            cdb0_vld = 1'($urandom_range(0, 1)); cdb0_tag = 4'($urandom_range(0, 7)); cdb0_val = $urandom;
            cdb1_vld = 1'($urandom_range(0, 1)); cdb1_tag = 4'($urandom_range(0, 7)); cdb1_val = $urandom;
            if (cdb1_tag == cdb0_tag) cdb1_tag = cdb0_tag ^ 4'd8;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
